// File: rtl/sdc_resp_if.sv
// Handshake and SPI pin bundle between the SD response receiver and its neighbours.
interface sdc_resp_if;
  logic        i_start;
  logic        i_long;
  logic        i_miso;
  logic        o_cs;
  logic        o_mosi;
  logic        o_sck_state;
  logic [7:0]  o_r1;
  logic [31:0] o_ext;
  logic        o_done;
  logic        o_timeout;
  logic        o_busy;

  modport slave (
    input  i_start, i_long, i_miso,
    output o_cs, o_mosi, o_sck_state, o_r1, o_ext, o_done, o_timeout, o_busy
  );

  modport master (
    output i_start, i_long, i_miso,
    input  o_cs, o_mosi, o_sck_state, o_r1, o_ext, o_done, o_timeout, o_busy
  );
endinterface

// File: rtl/sdc_resp.sv
// SPI-mode SD card response receiver: hunts for R1 within the NCR window, optionally
// captures 4 trailing bytes. Define SDC_RESP_BUSY_EN to add a post-response busy wait.
module sdc_resp #(
  parameter int unsigned NCR_MAX = 8
`ifdef SDC_RESP_BUSY_EN
  ,
  parameter int unsigned BUSY_MAX = 255
`endif
) (
  input logic       i_clk,
  input logic       i_rst,
  sdc_resp_if.slave bus
);

  localparam int unsigned NcrW = $clog2(NCR_MAX + 1);

  typedef enum logic [2:0] {
    StIdle,
    StHunt,
    StCheck,
    StBytes,
    StBytesGap,
    StBusy,
    StBusyGap,
    StFin
  } state_e;

`ifdef SDC_RESP_BUSY_EN
  localparam int unsigned BusyW = $clog2(BUSY_MAX + 1);
  localparam state_e      PostCapture = StBusy;
  localparam logic        PostSck = 1'b1;
  logic [BusyW-1:0] busy_cnt_q;
`else
  localparam state_e      PostCapture = StFin;
  localparam logic        PostSck = 1'b0;
`endif

  state_e          state_q;
  logic [7:0]      shift_q;
  logic [2:0]      bit_cnt_q;
  logic [1:0]      byte_cnt_q;
  logic [NcrW-1:0] ncr_q;
  logic            long_q;
  logic            cs_q;
  logic            sck_q;
  logic [7:0]      r1_q;
  logic [31:0]     ext_q;
  logic            done_q;
  logic            timeout_q;
  logic            busy_q;

  logic [7:0] byte_in;
  assign byte_in = {shift_q[6:0], bus.i_miso};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      ncr_q      <= '0;
      long_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      r1_q       <= 8'hFF;
      ext_q      <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef SDC_RESP_BUSY_EN
      busy_cnt_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          cs_q  <= 1'b1;
          sck_q <= 1'b0;
          if (bus.i_start) begin
            long_q     <= bus.i_long;
            ext_q      <= '0;
            r1_q       <= 8'hFF;
            timeout_q  <= 1'b0;
            ncr_q      <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
`ifdef SDC_RESP_BUSY_EN
            busy_cnt_q <= '0;
`endif
            cs_q       <= 1'b0;
            busy_q     <= 1'b1;
            sck_q      <= 1'b1;
            state_q    <= StHunt;
          end
        end

        // All byte-receive phases share the same 8-bit shift; the gap state decides what's next.
        StHunt, StBytes, StBusy: begin
          shift_q   <= byte_in;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            sck_q   <= 1'b0;
            state_q <= (state_q == StHunt)  ? StCheck :
                       (state_q == StBytes) ? StBytesGap : StBusyGap;
          end
        end

        StCheck: begin
          if (!shift_q[7]) begin
            r1_q <= shift_q;
            if (long_q) begin
              sck_q   <= 1'b1;
              state_q <= StBytes;
            end else begin
              sck_q   <= PostSck;
              state_q <= PostCapture;
            end
          end else if (ncr_q == NcrW'(NCR_MAX - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StFin;
          end else begin
            ncr_q   <= ncr_q + 1'b1;
            sck_q   <= 1'b1;
            state_q <= StHunt;
          end
        end

        StBytesGap: begin
          ext_q      <= {ext_q[23:0], shift_q};
          byte_cnt_q <= byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            sck_q   <= PostSck;
            state_q <= PostCapture;
          end else begin
            sck_q   <= 1'b1;
            state_q <= StBytes;
          end
        end

        StBusyGap: begin
`ifdef SDC_RESP_BUSY_EN
          if (shift_q != 8'h00) begin
            state_q <= StFin;
          end else if (busy_cnt_q == BusyW'(BUSY_MAX - 1)) begin
            timeout_q <= 1'b1;
            state_q   <= StFin;
          end else begin
            busy_cnt_q <= busy_cnt_q + 1'b1;
            sck_q      <= 1'b1;
            state_q    <= StBusy;
          end
`else
          state_q <= StFin;
`endif
        end

        StFin: begin
          sck_q   <= 1'b0;
          cs_q    <= 1'b1;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.o_cs        = cs_q;
  assign bus.o_mosi      = 1'b1;
  assign bus.o_sck_state = sck_q;
  assign bus.o_r1        = r1_q;
  assign bus.o_ext       = ext_q;
  assign bus.o_done      = done_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_busy      = busy_q;

endmodule

// File: tb/tb_sdc_resp.sv
// Bench for sdc_resp: card model feeds MISO bits whenever SCK is enabled; a scoreboard
// holds the expected response/latency of each started reception.
module tb_sdc_resp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef SDC_RESP_BUSY_EN
  localparam int BusyLat = 9;  // one trailing nonzero (0xFF) byte ends the busy wait
`else
  localparam int BusyLat = 0;
`endif

  sdc_resp_if bus ();

  sdc_resp #(
    .NCR_MAX(8)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [7:0]  r1;
    logic [31:0] ext;
    logic        to;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  logic bit_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   n_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Card: presents the next bit after each falling edge while SCK is enabled, idles high.
  always @(negedge clk) begin : card
    if (rst) bus.i_miso = 1'b1;
    else if (bus.o_sck_state) bus.i_miso = (bit_q.size() > 0) ? bit_q.pop_front() : 1'b1;
  end

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && bus.o_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check({e.tag, "_r1"}, 64'(bus.o_r1), 64'(e.r1));
        check({e.tag, "_ext"}, 64'(bus.o_ext), 64'(e.ext));
        check({e.tag, "_timeout"}, 64'(bus.o_timeout), 64'(e.to));
        check({e.tag, "_latency"}, 64'(cyc - start_cyc), 64'(e.lat));
        check({e.tag, "_cs_high"}, 64'(bus.o_cs), 64'(1));
        check({e.tag, "_busy_low"}, 64'(bus.o_busy), 64'(0));
      end
    end
  end

  task automatic load_bits(input int n, input logic [63:0] data);
    bit_q.delete();
    for (int i = 8 * n - 1; i >= 0; i--) bit_q.push_back(data[i]);
  endtask

  task automatic pulse_start(input logic long_i);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_long  = long_i;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_long  = 1'b0;
  endtask

  task automatic run(input string tag, input logic long_i, input int n, input logic [63:0] data,
                     input logic [7:0] r1, input logic [31:0] ext, input logic to,
                     input int lat, input bit restart);
    exp_t e;
    int   d0;
    e.tag = tag;
    e.r1  = r1;
    e.ext = ext;
    e.to  = to;
    e.lat = lat;
    load_bits(n, data);
    exp_q.push_back(e);
    d0 = n_done;
    pulse_start(long_i);
    start_cyc = cyc;
    check({tag, "_cs_low"}, 64'(bus.o_cs), 64'(0));
    check({tag, "_busy_high"}, 64'(bus.o_busy), 64'(1));
    check({tag, "_sck_on"}, 64'(bus.o_sck_state), 64'(1));
    if (restart) begin
      repeat (20) @(negedge clk);
      pulse_start(1'b1);
    end
    for (int i = 0; i < 200 && n_done == d0; i++) @(negedge clk);
    check({tag, "_done_seen"}, 64'(n_done != d0), 64'(1));
    repeat (4) @(negedge clk);
    check({tag, "_single_done"}, 64'(n_done - d0), 64'(1));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.i_start = 1'b0;
    bus.i_long  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs", 64'(bus.o_cs), 64'(1));
    check("rst_mosi", 64'(bus.o_mosi), 64'(1));
    check("rst_sck", 64'(bus.o_sck_state), 64'(0));
    check("rst_r1", 64'(bus.o_r1), 64'(8'hFF));
    check("rst_ext", 64'(bus.o_ext), 64'(0));
    check("rst_done", 64'(bus.o_done), 64'(0));
    check("rst_timeout", 64'(bus.o_timeout), 64'(0));
    check("rst_busy", 64'(bus.o_busy), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // MISO stuck high: eight filler bytes then timeout.
    run("ncr_timeout", 1'b0, 0, 64'h0, 8'hFF, 32'h0, 1'b1, 73, 1'b0);
    run("r1_byte2", 1'b0, 2, 64'hFF01, 8'h01, 32'h0, 1'b0, 19 + BusyLat, 1'b0);
    run("cmd8", 1'b1, 6, 64'hFF01_0000_01AA, 8'h01, 32'h0000_01AA, 1'b0, 55 + BusyLat, 1'b0);
    run("r1_byte8", 1'b0, 8, 64'hFFFF_FFFF_FFFF_FF00, 8'h00, 32'h0, 1'b0, 73 + BusyLat, 1'b1);
    run("long_byte1", 1'b1, 5, 64'h05_DEAD_BEEF, 8'h05, 32'hDEAD_BEEF, 1'b0, 46 + BusyLat,
        1'b0);
    check("mosi_idle", 64'(bus.o_mosi), 64'(1));

    // Reset after the second extended byte of a long response.
    begin
      int d0;
      load_bits(6, 64'hFF01_1122_3344);
      d0 = n_done;
      pulse_start(1'b1);
      repeat (40) @(negedge clk);
      check("pre_rst_cs", 64'(bus.o_cs), 64'(0));
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_cs", 64'(bus.o_cs), 64'(1));
      check("mid_rst_sck", 64'(bus.o_sck_state), 64'(0));
      check("mid_rst_busy", 64'(bus.o_busy), 64'(0));
      check("mid_rst_ext", 64'(bus.o_ext), 64'(0));
      bit_q.delete();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_rst_no_done", 64'(n_done - d0), 64'(0));
    end
    run("after_rst", 1'b0, 3, 64'hFFFF7F, 8'h7F, 32'h0, 1'b0, 28 + BusyLat, 1'b0);

`ifdef SDC_RESP_BUSY_EN
    // R1 0x00, then 3 busy bytes, then 0xFF releases: four busy-phase bytes.
    run("busy_wait", 1'b0, 5, 64'h00_0000_00FF, 8'h00, 32'h0, 1'b0, 46, 1'b0);
`endif

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sdc_resp.md
Name: sdc_resp

Overview:
SPI-mode SD card response receiver. It sits directly downstream of the command sender.
- Started on the sender's done pulse; keeps CS low and MOSI idle-high while it clocks bytes in from MISO.
- Hunts for the byte-aligned R1 start (bit7 = 0) within the NCR window.
- Captures R1 plus, for R3/R7, four trailing bytes; reports result or timeout to the init/control FSM.

Parameters:
NCR_MAX, 8, max number of 0xFF filler bytes tolerated before the R1 byte (timeout threshold)
BUSY_MAX, 255, max busy (0x00) bytes tolerated after R1 when SDC_RESP_BUSY_EN is defined

Ports:
i_clk  in  1  system clock; SCK = i_clk gated externally by o_sck_state
i_rst  in  1  asynchronous reset, active-high
i_start  in  1  one-cycle pulse, begin reception (tied to command sender done)
i_long  in  1  1 = 5-byte response (R3/R7), 0 = R1 only; sampled with i_start
i_miso  in  1  card data out, sampled on rising i_clk while o_sck_state = 1
o_cs  out  1  chip select, active-low
o_mosi  out  1  held 1 throughout
o_sck_state  out  1  SCK enable request
o_r1  out  8  captured R1 byte
o_ext  out  32  trailing 4 bytes, MSB-first (R7: {ver/volt, echo}); 0 for R1-only
o_done  out  1  one-cycle pulse, reception finished (valid or timeout)
o_timeout  out  1  set with o_done when NCR/busy window exceeded; held until next i_start
o_busy  out  1  high from accepted i_start until o_done

Behaviour:
- Clock and reset: all logic on posedge i_clk. Reset is async, active-high.
- Reset values: o_cs = 1, o_mosi = 1, o_sck_state = 0, o_r1 = 8'hFF, o_ext = 0, o_done = 0, o_timeout = 0, o_busy = 0, state = IDLE, counters = 0.
- IDLE:
  - o_cs = 1, o_sck_state = 0.
  - On i_start: latch i_long, clear o_ext/o_timeout/ncr counter, o_cs <= 0, o_busy <= 1, o_sck_state <= 1, go HUNT.
  - i_start while o_busy is ignored.
- HUNT:
  - Shift i_miso into shift reg MSB-first, one bit per cycle, for 8 cycles.
  - On the 8th bit, drop o_sck_state and go CHECK.
- CHECK (1 cycle, SCK gap):
  - If first-byte mode and byte[7] == 0: o_r1 <= byte; go BYTES if long, else FIN.
  - Else if ncr == NCR_MAX-1: o_timeout <= 1, go FIN.
  - Else ncr++, o_sck_state <= 1, back to HUNT.
- BYTES:
  - Receive 4 bytes, each 8 SCK cycles plus 1 gap cycle.
  - Each byte is shifted into o_ext from the LSB side, so byte 1 lands in o_ext[31:24].
  - After the 4th byte go FIN.
- FIN (1 cycle): o_sck_state = 0, o_cs <= 1, o_done <= 1, o_busy <= 0, go IDLE.
  - o_done is high exactly one cycle.
- Latency, R1 arriving on the k-th byte (k = 1..NCR_MAX): 9k + 1 cycles from i_start to o_done; add 36 cycles for long responses.
- Boundary conditions:
  - R1 on byte NCR_MAX is accepted, not timed out.
  - An R1 value 0xFF can never be captured (bit7 = 1 means filler).
  - Timeout path leaves o_r1 = 8'hFF and o_ext = 0.
- Reset mid-operation: immediate return to reset values; CS released asynchronously; no o_done.

Optional Feature:
- Macro SDC_RESP_BUSY_EN:
  - Defined: adds BUSYWAIT state, entered after R1 (and after the extended bytes if long) instead of FIN.
  - BUSYWAIT repeatedly receives bytes, same 8+1 cycle pattern, while the byte == 8'h00.
  - First nonzero byte goes to FIN.
  - After BUSY_MAX busy bytes: o_timeout <= 1, go FIN.
  - o_busy stays high during BUSYWAIT.
- Not defined: no BUSYWAIT state; FIN follows capture directly; BUSY_MAX unused.

Test Plan:
- R1 on 2nd byte, i_long = 0: MISO 0xFF, 0x01 -> o_r1 = 0x01, o_ext = 0, o_timeout = 0, o_done at cycle 19 after i_start, o_cs low cycles 1..19.
- CMD8-style: i_long = 1, MISO 0xFF, 0x01, 0x00, 0x00, 0x01, 0xAA -> o_r1 = 0x01, o_ext = 32'h000001AA, o_done at cycle 55.
- Timeout: MISO stuck 1, NCR_MAX = 8 -> o_done at cycle 73 with o_timeout = 1, o_r1 = 0xFF, o_cs back high.
- Boundary: R1 = 0x00 on byte 8 exactly -> accepted, o_timeout = 0. A second i_start pulse during reception -> ignored, single o_done.
- Reset mid-BYTES: assert i_rst after 2nd extended byte -> o_cs = 1 and o_sck_state = 0 immediately, no o_done. Fresh i_start then completes normally.
- With SDC_RESP_BUSY_EN: R1 0x00, then 3x 0x00, then 0xFF -> o_done after 4 busy-phase bytes, o_timeout = 0. With BUSY_MAX = 2 -> o_timeout = 1.
